// File: rtl/spi_regbank_pkg.sv
// Shared constants and helpers for the SPI command/register engine.
// Covers command byte field positions, fixed register addresses and default control bit indices.
package spi_regbank_pkg;

  localparam int CMD_WRITE_BIT = 7;
  localparam int CMD_ADDR_MSB  = 6;
  localparam int CMD_ADDR_LSB  = 0;

  localparam logic [6:0] REG_CONTROL = 7'h00;
  localparam logic [6:0] REG_STATUS  = 7'h00;
  localparam logic [6:0] REG_RESULT  = 7'h01;
  localparam logic [6:0] REG_ID      = 7'h7F;

  localparam int CTRL_RUN       = 0;
  localparam int CTRL_PHASE_ADJ = 2;
  localparam int CTRL_RESET_CLK = 4;
  localparam int CTRL_CLEAR_ERR = 8;

  // Burst successor: the last mapped register wraps to 0, anything else steps mod 128.
  function automatic logic [6:0] advance_addr(input logic [6:0] addr, input int num_regs);
    if (addr == 7'(num_regs - 1)) begin
      return 7'h00;
    end else begin
      return addr + 7'h01;
    end
  endfunction

endpackage

// File: rtl/spi_regbank_addr_tracker.sv
// Holds the current register address and write flag for the SPI register bank.
// A command takes priority over a word arriving in the same cycle; words advance the burst address.
module spi_regbank_addr_tracker
  import spi_regbank_pkg::*;
#(
  parameter int NUM_REGS       = 7,
  parameter int AUTO_INCREMENT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] command,
  input  logic       command_ready,
  input  logic       word_rx_complete,
  output logic [6:0] addr,
  output logic       wr,
  output logic [6:0] read_addr,
  output logic       word_accept,
  output logic       load
);

  logic [6:0] addr_r;
  logic       wr_r;
  logic       wr_next_s;

  // Next address/flag selection; read_addr is the address the parent reads for the reload.
  always_comb begin
    word_accept = word_rx_complete & ~command_ready;
    load        = command_ready | word_rx_complete;
    read_addr   = addr_r;
    wr_next_s   = wr_r;
    if (command_ready) begin
      read_addr = command[CMD_ADDR_MSB:CMD_ADDR_LSB];
      wr_next_s = command[CMD_WRITE_BIT];
    end else if (word_rx_complete && (AUTO_INCREMENT != 0) && (addr_r != REG_ID)) begin
      read_addr = advance_addr(addr_r, NUM_REGS);
    end else begin
      read_addr = addr_r;
    end
  end

  // Address and write flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_r <= 7'h00;
      wr_r   <= 1'b0;
    end else begin
      addr_r <= read_addr;
      wr_r   <= wr_next_s;
    end
  end

  assign addr = addr_r;
  assign wr   = wr_r;

endmodule

// File: rtl/spi_register_bank.sv
// Command/register engine between simple_spi and the measurement core: read mux, storage,
// control pulses/levels and a saturating illegal-write counter.
module spi_register_bank
  import spi_regbank_pkg::*;
#(
  parameter int                  DATA_WIDTH     = 32,
  parameter int                  NUM_REGS       = 7,
  parameter logic [DATA_WIDTH-1:0] DEVICE_ID    = 32'hC001CAFE,
  parameter logic [DATA_WIDTH-1:0] PULSE_MASK   = 32'h0000_0005,
  parameter logic [DATA_WIDTH-1:0] LATCH_MASK   = 32'h0000_0010,
  parameter int                  CLEAR_ERR_BIT  = CTRL_CLEAR_ERR,
  parameter int                  AUTO_INCREMENT = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [7:0]                       command,
  input  logic                             command_ready,
  input  logic [DATA_WIDTH-1:0]            word_received,
  input  logic                             word_rx_complete,
  output logic [DATA_WIDTH-1:0]            word_to_output,
  input  logic [DATA_WIDTH-1:0]            status_in,
  input  logic [DATA_WIDTH-1:0]            result_in,
  output logic [DATA_WIDTH-1:0]            control_pulse,
  output logic [DATA_WIDTH-1:0]            control_level,
  output logic [(NUM_REGS-2)*DATA_WIDTH-1:0] regs_flat,
  output logic [NUM_REGS-1:0]              reg_write_strobe,
  output logic [7:0]                       error_count
);

  logic [6:0]            addr_s;
  logic                  wr_s;
  logic [6:0]            read_addr_s;
  logic                  word_accept_s;
  logic                  load_s;
  logic                  wr_ctrl_s;
  logic                  wr_store_s;
  logic                  wr_illegal_s;
  logic [DATA_WIDTH-1:0] read_val_s;

  spi_regbank_addr_tracker #(
    .NUM_REGS       (NUM_REGS),
    .AUTO_INCREMENT (AUTO_INCREMENT)
  ) u_addr_tracker (
    .clk              (clk),
    .reset            (reset),
    .command          (command),
    .command_ready    (command_ready),
    .word_rx_complete (word_rx_complete),
    .addr             (addr_s),
    .wr               (wr_s),
    .read_addr        (read_addr_s),
    .word_accept      (word_accept_s),
    .load             (load_s)
  );

  // Classify an accepted write word by the current address.
  always_comb begin
    wr_ctrl_s    = word_accept_s & wr_s & (addr_s == REG_CONTROL);
    wr_store_s   = word_accept_s & wr_s & (addr_s >= 7'h02) & (addr_s <= 7'(NUM_REGS - 1));
    wr_illegal_s = word_accept_s & wr_s & ~wr_ctrl_s & ~wr_store_s;
  end

  // Read mux; a storage write in this cycle is forwarded when the reload targets the same register.
  always_comb begin
    read_val_s = {DATA_WIDTH{1'b0}};
    if (read_addr_s == REG_STATUS) begin
      read_val_s = status_in;
    end else if (read_addr_s == REG_RESULT) begin
      read_val_s = result_in;
    end else if (read_addr_s == REG_ID) begin
      read_val_s = DEVICE_ID;
    end else begin
      for (int i = 0; i < NUM_REGS - 2; i++) begin
        read_val_s = (read_addr_s != 7'(i + 2)) ? read_val_s :
                     (wr_store_s && (addr_s == read_addr_s)) ? word_received :
                     regs_flat[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Output word, storage, control outputs, strobes and error counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_to_output   <= {DATA_WIDTH{1'b0}};
      control_pulse    <= {DATA_WIDTH{1'b0}};
      control_level    <= {DATA_WIDTH{1'b0}};
      regs_flat        <= {((NUM_REGS-2)*DATA_WIDTH){1'b0}};
      reg_write_strobe <= {NUM_REGS{1'b0}};
      error_count      <= 8'h00;
    end else begin
      control_pulse    <= {DATA_WIDTH{1'b0}};
      reg_write_strobe <= {NUM_REGS{1'b0}};
      if (load_s) begin
        word_to_output <= read_val_s;
      end
      if (wr_ctrl_s) begin
        control_pulse       <= word_received & PULSE_MASK;
        control_level       <= word_received & LATCH_MASK;
        reg_write_strobe[0] <= 1'b1;
        if (word_received[CLEAR_ERR_BIT]) begin
          error_count <= 8'h00;
        end
      end
      for (int i = 0; i < NUM_REGS - 2; i++) begin
        if (wr_store_s && (addr_s == 7'(i + 2))) begin
          regs_flat[i*DATA_WIDTH +: DATA_WIDTH] <= word_received;
          reg_write_strobe[i+2]                 <= 1'b1;
        end
      end
      if (wr_illegal_s && (error_count != 8'hFF)) begin
        error_count <= error_count + 8'h01;
      end
    end
  end

endmodule

// File: tb/tb_spi_register_bank.sv
// Directed vector bench for spi_register_bank: a cycle table plus hand sequences for
// error saturation, reset mid-burst and a fixed-address (no auto-increment) instance.
module tb_spi_register_bank;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   command = 8'h00;
  logic         command_ready = 1'b0;
  logic [31:0]  word_received = 32'h0;
  logic         word_rx_complete = 1'b0;
  logic [31:0]  word_to_output;
  logic [31:0]  status_in = 32'h0000_00A5;
  logic [31:0]  result_in = 32'h0000_BEEF;
  logic [31:0]  control_pulse;
  logic [31:0]  control_level;
  logic [159:0] regs_flat;
  logic [6:0]   reg_write_strobe;
  logic [7:0]   error_count;

  logic [7:0]   command2 = 8'h00;
  logic         command_ready2 = 1'b0;
  logic [31:0]  word_received2 = 32'h0;
  logic         word_rx_complete2 = 1'b0;
  logic [31:0]  word_to_output2;
  logic [31:0]  control_pulse2;
  logic [31:0]  control_level2;
  logic [63:0]  regs_flat2;
  logic [3:0]   reg_write_strobe2;
  logic [7:0]   error_count2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spi_register_bank dut (
    .clk(clk), .reset(reset), .command(command), .command_ready(command_ready),
    .word_received(word_received), .word_rx_complete(word_rx_complete),
    .word_to_output(word_to_output), .status_in(status_in), .result_in(result_in),
    .control_pulse(control_pulse), .control_level(control_level), .regs_flat(regs_flat),
    .reg_write_strobe(reg_write_strobe), .error_count(error_count)
  );

  spi_register_bank #(.NUM_REGS(4), .AUTO_INCREMENT(0)) dut_fixed (
    .clk(clk), .reset(reset), .command(command2), .command_ready(command_ready2),
    .word_received(word_received2), .word_rx_complete(word_rx_complete2),
    .word_to_output(word_to_output2), .status_in(32'h0000_0001), .result_in(32'h0000_0002),
    .control_pulse(control_pulse2), .control_level(control_level2), .regs_flat(regs_flat2),
    .reg_write_strobe(reg_write_strobe2), .error_count(error_count2)
  );

  typedef struct {
    logic        cv;
    logic [7:0]  cmd;
    logic        wv;
    logic [31:0] word;
    logic [31:0] e_wto;
    logic [31:0] e_pulse;
    logic [31:0] e_level;
    logic [6:0]  e_strobe;
    logic [7:0]  e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic cv, input logic [7:0] cmd, input logic wv, input logic [31:0] word);
    command          = cmd;
    command_ready    = cv;
    word_received    = word;
    word_rx_complete = wv;
    @(posedge clk);
    #1;
    command_ready    = 1'b0;
    word_rx_complete = 1'b0;
  endtask

  task automatic drive2(input logic cv, input logic [7:0] cmd, input logic wv, input logic [31:0] word);
    command2          = cmd;
    command_ready2    = cv;
    word_received2    = word;
    word_rx_complete2 = wv;
    @(posedge clk);
    #1;
    command_ready2    = 1'b0;
    word_rx_complete2 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //                cv    cmd    wv    word          wto            pulse  level  strobe err
    vecs.push_back('{1'b1, 8'h7F, 1'b0, 32'h0,    32'hC001CAFE, 32'h0, 32'h00, 7'h00, 8'd0});
    vecs.push_back('{1'b1, 8'h82, 1'b0, 32'h0,    32'h0,        32'h0, 32'h00, 7'h00, 8'd0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 32'h11,   32'h0,        32'h0, 32'h00, 7'h04, 8'd0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 32'h22,   32'h0,        32'h0, 32'h00, 7'h08, 8'd0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 32'h33,   32'h0,        32'h0, 32'h00, 7'h10, 8'd0});
    vecs.push_back('{1'b1, 8'h02, 1'b0, 32'h0,    32'h11,       32'h0, 32'h00, 7'h00, 8'd0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 32'h0,    32'h22,       32'h0, 32'h00, 7'h00, 8'd0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 32'h0,    32'h33,       32'h0, 32'h00, 7'h00, 8'd0});
    vecs.push_back('{1'b1, 8'h80, 1'b0, 32'h0,    32'hA5,       32'h0, 32'h00, 7'h00, 8'd0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 32'h15,   32'hBEEF,     32'h5, 32'h10, 7'h01, 8'd0});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 32'h0,    32'hBEEF,     32'h0, 32'h10, 7'h00, 8'd0});
    vecs.push_back('{1'b1, 8'h80, 1'b0, 32'h0,    32'hA5,       32'h0, 32'h10, 7'h00, 8'd0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 32'h0,    32'hBEEF,     32'h0, 32'h00, 7'h01, 8'd0});
    vecs.push_back('{1'b1, 8'h81, 1'b0, 32'h0,    32'hBEEF,     32'h0, 32'h00, 7'h00, 8'd0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 32'hDEAD, 32'h11,       32'h0, 32'h00, 7'h00, 8'd1});
    vecs.push_back('{1'b1, 8'h86, 1'b0, 32'h0,    32'h0,        32'h0, 32'h00, 7'h00, 8'd1});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 32'h66,   32'hA5,       32'h0, 32'h00, 7'h40, 8'd1});
    vecs.push_back('{1'b1, 8'h82, 1'b1, 32'h99,   32'h11,       32'h0, 32'h00, 7'h00, 8'd1});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 32'h44,   32'h22,       32'h0, 32'h00, 7'h04, 8'd1});
    vecs.push_back('{1'b1, 8'h8A, 1'b0, 32'h0,    32'h0,        32'h0, 32'h00, 7'h00, 8'd1});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 32'h1,    32'h0,        32'h0, 32'h00, 7'h00, 8'd2});
    vecs.push_back('{1'b1, 8'hFF, 1'b0, 32'h0,    32'hC001CAFE, 32'h0, 32'h00, 7'h00, 8'd2});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 32'h5,    32'hC001CAFE, 32'h0, 32'h00, 7'h00, 8'd3});

    repeat (3) @(posedge clk);
    #1;
    check("reset_wto", word_to_output, 32'h0);
    check("reset_err", error_count, 8'h0);
    check("reset_regs", regs_flat[63:0], 64'h0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].cv, vecs[i].cmd, vecs[i].wv, vecs[i].word);
      check($sformatf("v%0d_wto", i), word_to_output, vecs[i].e_wto);
      check($sformatf("v%0d_pulse", i), control_pulse, vecs[i].e_pulse);
      check($sformatf("v%0d_level", i), control_level, vecs[i].e_level);
      check($sformatf("v%0d_strobe", i), reg_write_strobe, vecs[i].e_strobe);
      check($sformatf("v%0d_err", i), error_count, vecs[i].e_err);
    end

    check("reg2", regs_flat[31:0], 32'h44);
    check("reg3", regs_flat[63:32], 32'h22);
    check("reg4", regs_flat[95:64], 32'h33);
    check("reg5", regs_flat[127:96], 32'h0);
    check("reg6", regs_flat[159:128], 32'h66);

    // Saturation of the illegal-write counter, then clear through the control register.
    drive(1'b1, 8'h81, 1'b0, 32'h0);
    for (int k = 0; k < 300; k++) begin
      drive(1'b1, 8'h81, 1'b0, 32'h0);
      drive(1'b0, 8'h00, 1'b1, 32'hDEAD);
    end
    check("err_saturated", error_count, 8'hFF);
    drive(1'b1, 8'h80, 1'b0, 32'h0);
    drive(1'b0, 8'h00, 1'b1, 32'h100);
    check("err_cleared", error_count, 8'h00);
    check("clear_pulse", control_pulse, 32'h0);

    // Reset in the middle of a burst clears everything immediately.
    drive(1'b1, 8'h80, 1'b0, 32'h0);
    drive(1'b0, 8'h00, 1'b1, 32'h10);
    check("pre_reset_level", control_level, 32'h10);
    drive(1'b1, 8'h82, 1'b0, 32'h0);
    drive(1'b0, 8'h00, 1'b1, 32'h1);
    check("pre_reset_strobe", reg_write_strobe, 7'h04);
    #2 reset = 1'b1;
    #1;
    check("midreset_wto", word_to_output, 32'h0);
    check("midreset_level", control_level, 32'h0);
    check("midreset_strobe", reg_write_strobe, 7'h00);
    check("midreset_regs", regs_flat, 160'h0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 8'h00, 1'b1, 32'h55);
    check("post_reset_regs", regs_flat, 160'h0);
    check("post_reset_strobe", reg_write_strobe, 7'h00);
    check("post_reset_err", error_count, 8'h00);
    check("post_reset_wto", word_to_output, 32'hBEEF);

    // Fixed-address instance: reload returns the freshly written storage value.
    drive2(1'b1, 8'h83, 1'b0, 32'h0);
    check("fixed_cmd_wto", word_to_output2, 32'h0);
    drive2(1'b0, 8'h00, 1'b1, 32'h77);
    check("fixed_bypass1", word_to_output2, 32'h77);
    check("fixed_strobe", reg_write_strobe2, 4'b1000);
    drive2(1'b0, 8'h00, 1'b1, 32'h88);
    check("fixed_bypass2", word_to_output2, 32'h88);
    check("fixed_reg3", regs_flat2[63:32], 32'h88);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
